// File: rtl/seq_alu_core.sv
// -----------------------------------------------------------------------------
// seq_alu_core
//   Parametrised multi-cycle integer ALU: add, sub, signed radix-2 Booth
//   multiply and unsigned restoring divide, with a start/busy/done handshake.
//   Control FSM, iteration counter and the A/Q/M/q_-1 datapath live here.
//
// Optional feature macro: SEQ_ALU_MUL_EARLY_TERM_EN
//   When defined, a multiply finishes as soon as the remaining multiplier bits
//   would only produce Booth no-ops; the pending shift is applied in one step.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_b      in   asynchronous active-low reset
//   start      in   operation request, sampled only while busy=0
//   opcode     in   00 add, 01 sub, 10 mul (signed), 11 div (unsigned)
//   a, b       in   operands (WIDTH bits)
//   busy       out  operation in progress
//   done       out  one-cycle pulse, results valid from this cycle
//   result_lo  out  sum/diff, product low half, quotient
//   result_hi  out  carry/borrow, product high half, remainder
//   ovf        out  signed overflow (add/sub only)
//   dz         out  divide by zero (div only)
// -----------------------------------------------------------------------------
module seq_alu_core #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             ovf,
    output logic             dz
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADDSUB, MUL, DIV} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    logic [WIDTH-1:0] q_reg, q_nx;
    logic [WIDTH-1:0] m_reg, m_nx;
    logic             q_m1, q_m1_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             is_sub, is_sub_nx;
    logic             is_dz, is_dz_nx;
    logic             busy_nx, done_nx, ovf_nx, dz_nx;
    logic [WIDTH-1:0] lo_nx, hi_nx;

    // Add/sub in WIDTH+1 bits: the top bit is the carry-out, or the borrow.
    logic [WIDTH:0] addsub_res;
    logic           addsub_ovf;
    assign addsub_res = is_sub ? ({1'b0, acc} - {1'b0, m_reg})
                               : ({1'b0, acc} + {1'b0, m_reg});
    assign addsub_ovf = is_sub
        ? ((acc[WIDTH-1] != m_reg[WIDTH-1]) && (addsub_res[WIDTH-1] != acc[WIDTH-1]))
        : ((acc[WIDTH-1] == m_reg[WIDTH-1]) && (addsub_res[WIDTH-1] != acc[WIDTH-1]));

    // Booth step in WIDTH+1 bits so that A - M with M = -2^(WIDTH-1) keeps its
    // true sign; the arithmetic shift then takes the sign from bit WIDTH.
    logic [WIDTH:0] booth_sum;
    always_comb begin
        case ({q_reg[0], q_m1})
            2'b10:   booth_sum = {acc[WIDTH-1], acc} - {m_reg[WIDTH-1], m_reg};
            2'b01:   booth_sum = {acc[WIDTH-1], acc} + {m_reg[WIDTH-1], m_reg};
            default: booth_sum = {acc[WIDTH-1], acc};
        endcase
    end

    // Restoring divide: shifted partial remainder is WIDTH+1 bits wide.
    logic [WIDTH:0] rem_sh;
    logic           trial_ge;
    assign rem_sh   = {acc, q_reg[WIDTH-1]};
    assign trial_ge = rem_sh >= {1'b0, m_reg};

`ifdef SEQ_ALU_MUL_EARLY_TERM_EN
    // After cnt iterations the unprocessed multiplier bits sit in
    // q_reg[WIDTH-1-cnt:0]; if they all match q_-1, every remaining step is
    // a no-op and only the accumulated shift is left to apply.
    logic [WIDTH-1:0]   unproc_mask;
    logic               mul_skip;
    logic [CNT_W-1:0]   skip_shamt;
    logic [2*WIDTH-1:0] skip_prod;
    assign unproc_mask = {WIDTH{1'b1}} >> cnt;
    assign mul_skip    = ((q_reg ^ {WIDTH{q_m1}}) & unproc_mask) == '0;
    assign skip_shamt  = CNT_W'(WIDTH) - cnt;
    assign skip_prod   = $signed({acc, q_reg}) >>> skip_shamt;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_nx  = state;
        acc_nx    = acc;
        q_nx      = q_reg;
        m_nx      = m_reg;
        q_m1_nx   = q_m1;
        cnt_nx    = cnt;
        is_sub_nx = is_sub;
        is_dz_nx  = is_dz;
        busy_nx   = busy;
        done_nx   = 1'b0;
        lo_nx     = result_lo;
        hi_nx     = result_hi;
        ovf_nx    = ovf;
        dz_nx     = dz;

        case (state)
            IDLE: begin
                if (start) begin
                    busy_nx   = 1'b1;
                    cnt_nx    = '0;
                    is_sub_nx = (opcode == 2'b01);
                    is_dz_nx  = 1'b0;
                    case (opcode)
                        2'b10: begin
                            acc_nx   = '0;
                            q_nx     = b;
                            m_nx     = a;
                            q_m1_nx  = 1'b0;
                            state_nx = MUL;
                        end
                        2'b11: begin
                            if (b == '0) begin
                                // Divide by zero resolves in one step.
                                is_dz_nx = 1'b1;
                                acc_nx   = a;
                                state_nx = ADDSUB;
                            end else begin
                                acc_nx   = '0;
                                q_nx     = a;
                                m_nx     = b;
                                state_nx = DIV;
                            end
                        end
                        default: begin
                            acc_nx   = a;
                            m_nx     = b;
                            state_nx = ADDSUB;
                        end
                    endcase
                end
            end

            ADDSUB: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
                done_nx  = 1'b1;
                if (is_dz) begin
                    lo_nx  = '1;
                    hi_nx  = acc;
                    ovf_nx = 1'b0;
                    dz_nx  = 1'b1;
                end else begin
                    lo_nx  = addsub_res[WIDTH-1:0];
                    hi_nx  = WIDTH'(addsub_res[WIDTH]);
                    ovf_nx = addsub_ovf;
                    dz_nx  = 1'b0;
                end
            end

            MUL: begin
                acc_nx  = booth_sum[WIDTH:1];
                q_nx    = {booth_sum[0], q_reg[WIDTH-1:1]};
                q_m1_nx = q_reg[0];
                if (cnt == LAST) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    lo_nx    = q_nx;
                    hi_nx    = acc_nx;
                    ovf_nx   = 1'b0;
                    dz_nx    = 1'b0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
`ifdef SEQ_ALU_MUL_EARLY_TERM_EN
                if (mul_skip) begin
                    {acc_nx, q_nx} = skip_prod;
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    lo_nx    = skip_prod[WIDTH-1:0];
                    hi_nx    = skip_prod[2*WIDTH-1:WIDTH];
                    ovf_nx   = 1'b0;
                    dz_nx    = 1'b0;
                end
`endif
            end

            DIV: begin
                if (trial_ge) begin
                    acc_nx = rem_sh[WIDTH-1:0] - m_reg;
                    q_nx   = {q_reg[WIDTH-2:0], 1'b1};
                end else begin
                    acc_nx = rem_sh[WIDTH-1:0];
                    q_nx   = {q_reg[WIDTH-2:0], 1'b0};
                end
                if (cnt == LAST) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    lo_nx    = q_nx;
                    hi_nx    = acc_nx;
                    ovf_nx   = 1'b0;
                    dz_nx    = 1'b0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            acc       <= '0;
            q_reg     <= '0;
            m_reg     <= '0;
            q_m1      <= 1'b0;
            cnt       <= '0;
            is_sub    <= 1'b0;
            is_dz     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            q_reg     <= q_nx;
            m_reg     <= m_nx;
            q_m1      <= q_m1_nx;
            cnt       <= cnt_nx;
            is_sub    <= is_sub_nx;
            is_dz     <= is_dz_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            result_lo <= lo_nx;
            result_hi <= hi_nx;
            ovf       <= ovf_nx;
            dz        <= dz_nx;
        end
    end

endmodule
